uart_wb_fifo: RTL

// Wishbone classic slave UART with parametrised TX/RX FIFOs, a runtime baud divisor, sticky error flags and an irq.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 44 ++++
 rtl/uart_wb_fifo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions, the shared tx/rx state type and 8N1 frame constants
package uart_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;
    localparam int ST_RX_VALID  = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_RX_OVF    = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_OVF    = 6;
    localparam int ST_TX_BUSY   = 7;
    localparam int DATA_BITS = 8;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO with extra-MSB pointers
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and data (ignored when full unless a pop frees a slot)
//   pop, dout       read request and head-of-queue data (pop ignored when empty)
//   full, empty     occupancy flags
//   count           number of stored entries
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_wb_fifo.sv
// uart_wb_fifo: Wishbone classic slave 8N1 UART with TX/RX FIFOs, runtime divisor, sticky errors and irq
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i    Wishbone cycle / strobe
//   wb_we_i, wb_adr_i     write enable, word address (bits [3:2] pick DATA/STATUS/DIV/IRQ_EN)
//   wb_dat_i, wb_dat_o    write data, read data (zero outside the ack cycle)
//   wb_ack_o              one-cycle acknowledge
//   rx, tx                serial in (asynchronous), serial out (idles high)
//   irq                   level interrupt from enabled rx_valid / tx_empty
module uart_wb_fifo #(
    parameter int CLK_FREQ = 200_000_000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    import uart_pkg::*;
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD - 1);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);

    logic [1:0] sel;
    logic wr, rd;
    logic [15:0] div;
    logic [1:0] irq_en;
    logic rx_ovf, frame_err, tx_ovf;
    logic rx_ovf_set, frame_err_set, tx_ovf_set;
    logic [2:0] clr;
    logic [31:0] rdata;
    logic [7:0] status;
    logic unused_bits;

    logic tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic [TX_AW:0] tx_count;
    logic rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic [RX_AW:0] rx_count;

    uart_state_t tx_st, rx_st;
    logic [15:0] tx_div, tx_cnt, rx_div, rx_cnt;
    logic [7:0] tx_sh, rx_sh;
    logic [2:0] tx_bit, rx_bit;
    logic tx_bit_end, rx_sample;
    logic rx_s1, rx_s2, rx_d, rx_hold;

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:16]};

    // Bus: every side effect is qualified by the ack cycle
    assign sel = wb_adr_i[3:2];
    assign wr  = wb_ack_o && wb_we_i;
    assign rd  = wb_ack_o && !wb_we_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_ack_o <= 1'b0;
        else wb_ack_o <= wb_cyc_i && wb_stb_i && !wb_ack_o;
    end

    assign clr = (wr && sel == REG_STATUS) ? wb_dat_i[ST_TX_OVF:ST_RX_OVF] : 3'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= DIV_RST;
            irq_en    <= 2'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
        end else begin
            if (wr && sel == REG_DIV) div <= wb_dat_i[15:0];
            if (wr && sel == REG_IRQ_EN) irq_en <= wb_dat_i[1:0];
            // a set in the same cycle overrides a software clear
            rx_ovf    <= rx_ovf_set || (rx_ovf && !clr[0]);
            frame_err <= frame_err_set || (frame_err && !clr[1]);
            tx_ovf    <= tx_ovf_set || (tx_ovf && !clr[2]);
        end
    end

    assign status = {tx_st != S_IDLE, tx_ovf, frame_err, rx_ovf,
                     tx_count == TX_FULL_CNT, tx_empty, rx_count == RX_FULL_CNT, !rx_empty};
    assign rdata = sel == REG_DATA   ? (rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head}) :
                   sel == REG_STATUS ? {24'd0, status} :
                   sel == REG_DIV    ? {16'd0, div} : {30'd0, irq_en};
    assign wb_dat_o = wb_ack_o ? rdata : 32'd0;
    assign irq = |(irq_en & {tx_empty, !rx_empty});

    // FIFOs
    assign tx_push    = wr && sel == REG_DATA;
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_pop     = rd && sel == REG_DATA;
    assign rx_ovf_set = rx_push && rx_full && !rx_pop;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .din(wb_dat_i[7:0]), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_sh), .pop(rx_pop),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // TX: the divisor is latched per frame so a DIV write never stretches a frame in flight
    assign tx_bit_end = tx_cnt == 16'd0;
    assign tx_pop = !tx_empty && (tx_st == S_IDLE || (tx_st == S_STOP && tx_bit_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st  <= S_IDLE;
            tx     <= 1'b1;
            tx_div <= '0;
            tx_cnt <= '0;
            tx_sh  <= '0;
            tx_bit <= '0;
        end else if (tx_pop) begin
            tx_st  <= S_START;
            tx     <= START_BIT;
            tx_div <= div;
            tx_cnt <= div;
            tx_sh  <= tx_head;
        end else if (tx_st != S_IDLE) begin
            if (!tx_bit_end) tx_cnt <= tx_cnt - 1'b1;
            else begin
                tx_cnt <= tx_div;
                case (tx_st)
                    S_START: begin
                        tx_st  <= S_DATA;
                        tx     <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= '0;
                    end
                    S_DATA: begin
                        tx_st  <= (tx_bit == LAST_BIT) ? S_STOP : S_DATA;
                        tx     <= (tx_bit == LAST_BIT) ? STOP_BIT : tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= tx_bit + 1'b1;
                    end
                    default: tx_st <= S_IDLE;
                endcase
            end
        end
    end

    // RX: counter runs half a bit into START, then samples each following bit centre
    assign rx_sample     = rx_cnt == 16'd0;
    assign rx_push       = rx_st == S_STOP && rx_sample && rx_s2 && !rx_hold;
    assign frame_err_set = rx_st == S_STOP && rx_sample && !rx_s2 && !rx_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_d    <= 1'b1;
            rx_st   <= S_IDLE;
            rx_div  <= '0;
            rx_cnt  <= '0;
            rx_sh   <= '0;
            rx_bit  <= '0;
            rx_hold <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            if (rx_st == S_IDLE) begin
                if (rx_d && !rx_s2) begin
                    rx_st  <= S_START;
                    rx_div <= div;
                    rx_cnt <= div >> 1;
                end
            end else if (!rx_sample) rx_cnt <= rx_cnt - 1'b1;
            else begin
                rx_cnt <= rx_div;
                case (rx_st)
                    S_START: begin
                        rx_st  <= rx_s2 ? S_IDLE : S_DATA;
                        rx_bit <= '0;
                    end
                    S_DATA: begin
                        rx_st  <= (rx_bit == LAST_BIT) ? S_STOP : S_DATA;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 1'b1;
                    end
                    default: begin
                        // a low stop bit parks here, polling every clock, until the line idles high
                        rx_st   <= rx_s2 ? S_IDLE : S_STOP;
                        rx_hold <= !rx_s2;
                        rx_cnt  <= '0;
                    end
                endcase
            end
        end
    end
endmodule
